// File: rtl/uart_pkg.sv
// Shared definitions for the UART datapath: FSM encoding, frame length and
// the bit-timing helpers used to size counters at elaboration time.
package uart_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    localparam int FRAME_BITS = 10;

    function automatic int symbol_edge_time(input int clock_freq, input int baud_rate);
        return clock_freq / baud_rate;
    endfunction

    // Width needed to hold 0..value-1, never less than one bit.
    function automatic int clog2_min1(input int value);
        int w;
        w = 1;
        while ((1 << w) < value) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Byte-write handshake between the UART decoder (master) and the transmitter.
interface uart_tx_fifo_if;
    logic [7:0] DataIn;
    logic       DataInValid;
    logic       DataInReady;

    modport master (output DataIn, output DataInValid, input DataInReady);
    modport slave  (input DataIn, input DataInValid, output DataInReady);
endinterface

// File: rtl/uart_tx_fifo_sync_fifo.sv
// Single-clock circular FIFO with occupancy count; push/pop self-guard
// against full/empty so callers may drive them unqualified.
module sync_fifo
    import uart_pkg::*;
#(
    parameter int  WIDTH = 8,
    parameter int  DEPTH = 4,
    localparam int AW    = clog2_min1(DEPTH)
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [AW:0]      count,
    output logic             full,
    output logic             empty
);

    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("sync_fifo: DEPTH must be a power of two and at least 2");
    end

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full      = (count_q == FULL_COUNT);
    assign empty     = (count_q == '0);
    assign count     = count_q;
    assign dout      = mem_q[rd_ptr_q];
    assign push_ok_s = push && !full;
    assign pop_ok_s  = pop && !empty;

    // Next-state for storage, pointers and occupancy.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok_s) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_ok_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_ok_s, pop_ok_s})
            2'b10:   count_d = count_q + (AW + 1)'(1);
            2'b01:   count_d = count_q - (AW + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    // State registers.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: bytes queue in a FIFO and are serialised
// one frame at a time, with a single idle cycle between back-to-back frames.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int  CLOCK_FREQ = 33_000_000,
    parameter int  BAUD_RATE  = 115_200,
    parameter int  FIFO_DEPTH = 4,
    localparam int CW_FIFO    = clog2_min1(FIFO_DEPTH)
) (
    input  logic                Clock,
    input  logic                Reset,
    uart_tx_fifo_if.slave       in_if,
    output logic                SOut,
    output logic                TxBusy,
    output logic [CW_FIFO:0]    FifoCount
);

    localparam int SYMBOL_EDGE_TIME = symbol_edge_time(CLOCK_FREQ, BAUD_RATE);
    localparam int CW               = clog2_min1(SYMBOL_EDGE_TIME);
    localparam logic [CW-1:0] BAUD_LAST = CW'(SYMBOL_EDGE_TIME - 1);

    if (SYMBOL_EDGE_TIME < 2) begin : g_bad_baud
        $error("uart_tx_fifo: CLOCK_FREQ/BAUD_RATE must be at least 2");
    end

    logic [1:0]            state_q, state_d;
    logic [CW-1:0]         baud_q, baud_d;
    logic [2:0]            bit_q, bit_d;
    logic [FRAME_BITS-1:0] shift_q, shift_d;
    logic                  sout_q, sout_d;
    logic                  busy_q, busy_d;

    logic                  push_s;
    logic                  pop_s;
    logic                  baud_wrap_s;
    logic [7:0]            fifo_dout_s;
    logic [CW_FIFO:0]      fifo_count_s;
    logic                  fifo_full_s;
    logic                  fifo_empty_s;

    assign in_if.DataInReady = !fifo_full_s;
    assign push_s            = in_if.DataInValid && !fifo_full_s;
    assign pop_s             = (state_q == ST_IDLE) && !fifo_empty_s;
    assign baud_wrap_s       = (baud_q == BAUD_LAST);

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .Clock (Clock),
        .Reset (Reset),
        .push  (push_s),
        .pop   (pop_s),
        .din   (in_if.DataIn),
        .dout  (fifo_dout_s),
        .count (fifo_count_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

    // Frame sequencer: baud timing, bit counting and the shift register.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        case (state_q)
            ST_IDLE: begin
                baud_d = '0;
                bit_d  = 3'd0;
                if (pop_s) begin
                    shift_d = {1'b1, fifo_dout_s, 1'b0};
                    state_d = ST_START;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (baud_wrap_s) begin
                    baud_d  = '0;
                    bit_d   = 3'd0;
                    shift_d = {1'b1, shift_q[FRAME_BITS-1:1]};
                    state_d = ST_DATA;
                end else begin
                    baud_d = baud_q + CW'(1);
                end
            end
            ST_DATA: begin
                if (baud_wrap_s) begin
                    baud_d  = '0;
                    shift_d = {1'b1, shift_q[FRAME_BITS-1:1]};
                    if (bit_q == 3'd7) begin
                        state_d = ST_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + CW'(1);
                end
            end
            ST_STOP: begin
                if (baud_wrap_s) begin
                    baud_d  = '0;
                    state_d = ST_IDLE;
                end else begin
                    baud_d = baud_q + CW'(1);
                end
            end
            default: begin
                baud_d  = '0;
                bit_d   = 3'd0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Line level and busy flag, registered one cycle behind the sequencer.
    always_comb begin
        sout_d = 1'b1;
        case (state_q)
            ST_IDLE:  sout_d = 1'b1;
            ST_START: sout_d = 1'b0;
            ST_DATA:  sout_d = shift_q[0];
            ST_STOP:  sout_d = 1'b1;
            default:  sout_d = 1'b1;
        endcase
        busy_d = (state_q != ST_IDLE) || (fifo_count_s != '0);
    end

    // State registers.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q <= ST_IDLE;
            baud_q  <= '0;
            bit_q   <= 3'd0;
            shift_q <= '1;
            sout_q  <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            sout_q  <= sout_d;
            busy_q  <= busy_d;
        end
    end

    assign SOut      = sout_q;
    assign TxBusy    = busy_q;
    assign FifoCount = fifo_count_s;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo at 10 clocks per bit with a serial
// decoder that collects received bytes and frame start times.
module tb_uart_tx_fifo;

    logic       clk;
    logic       rst_n;
    logic       sout;
    logic       busy;
    logic [2:0] fcount;

    int checks;
    int errors;
    int cyc;

    logic [7:0] rx_q[$];
    int         starts_q[$];

    uart_tx_fifo_if u_if ();

    uart_tx_fifo #(
        .CLOCK_FREQ (100),
        .BAUD_RATE  (10),
        .FIFO_DEPTH (4)
    ) dut (
        .Clock     (clk),
        .Reset     (rst_n),
        .in_if     (u_if),
        .SOut      (sout),
        .TxBusy    (busy),
        .FifoCount (fcount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] b);
        u_if.DataIn      = b;
        u_if.DataInValid = 1'b1;
        tick();
        u_if.DataInValid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget && busy; i++) begin
            tick();
        end
        check_eq("idle_reached", {31'd0, busy}, 32'd0);
    endtask

    // Serial decoder: samples mid-bit; aborts any partial frame on reset.
    initial begin
        bit         mon_busy;
        int         mon_cnt;
        logic [7:0] mon_byte;
        mon_busy = 1'b0;
        mon_cnt  = 0;
        mon_byte = 8'h00;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                mon_busy = 1'b0;
            end else if (!mon_busy) begin
                if (sout == 1'b0) begin
                    mon_busy = 1'b1;
                    mon_cnt  = 0;
                    starts_q.push_back(cyc);
                end
            end else begin
                mon_cnt++;
                if (mon_cnt == 5) begin
                    check_eq("mon_start", {31'd0, sout}, 32'd0);
                end else if (mon_cnt >= 15 && mon_cnt <= 85 && (mon_cnt % 10) == 5) begin
                    mon_byte[(mon_cnt - 15) / 10] = sout;
                end else if (mon_cnt == 95) begin
                    check_eq("mon_stop", {31'd0, sout}, 32'd1);
                    rx_q.push_back(mon_byte);
                    mon_busy = 1'b0;
                end
            end
        end
    end

    initial begin
        logic [7:0] a5;
        logic [7:0] tbl2 [5];
        int         cnt2 [5];
        int         acc;
        int         push_cyc;
        bit         rdy;
        bit         low_seen;
        logic       exp_s;

        checks = 0;
        errors = 0;
        cyc    = 0;
        u_if.DataIn      = 8'h00;
        u_if.DataInValid = 1'b0;
        rst_n = 1'b0;
        #23;
        check_eq("rst_sout",  {31'd0, sout}, 32'd1);
        check_eq("rst_busy",  {31'd0, busy}, 32'd0);
        check_eq("rst_count", {29'd0, fcount}, 32'd0);
        check_eq("rst_ready", {31'd0, u_if.DataInReady}, 32'd1);
        rst_n = 1'b1;
        repeat (3) tick();

        // 1: single frame of 0xA5, checked cycle by cycle.
        a5 = 8'hA5;
        rx_q.delete();
        push_byte(a5);
        for (int t = 0; t <= 102; t++) begin
            if (t > 0) tick();
            if (t < 2)       exp_s = 1'b1;
            else if (t < 12) exp_s = 1'b0;
            else if (t < 92) exp_s = a5[(t - 12) / 10];
            else             exp_s = 1'b1;
            check_eq($sformatf("t1_sout_%0d", t), {31'd0, sout}, {31'd0, exp_s});
            check_eq($sformatf("t1_busy_%0d", t), {31'd0, busy},
                     (t >= 1 && t <= 101) ? 32'd1 : 32'd0);
            if (t < 2) check_eq($sformatf("t1_count_%0d", t), {29'd0, fcount}, (t == 0) ? 32'd1 : 32'd0);
        end
        repeat (3) tick();
        check_eq("t1_rx_n", rx_q.size(), 32'd1);
        if (rx_q.size() > 0) check_eq("t1_rx", {24'd0, rx_q[0]}, 32'hA5);

        // 2-4: burst of five, overflow attempt, push+pop on the pop cycle.
        tbl2 = '{8'h00, 8'hFF, 8'h55, 8'h3C, 8'h81};
        cnt2 = '{1, 1, 2, 3, 4};
        rx_q.delete();
        starts_q.delete();
        acc      = 0;
        push_cyc = 0;
        u_if.DataIn      = tbl2[0];
        u_if.DataInValid = 1'b1;
        for (int c = 0; c < 10 && acc < 5; c++) begin
            rdy = u_if.DataInReady;
            check_eq("t2_ready_fill", {31'd0, rdy}, 32'd1);
            tick();
            if (rdy) begin
                if (acc == 0) push_cyc = cyc;
                check_eq($sformatf("t2_count_%0d", acc), {29'd0, fcount}, cnt2[acc]);
                acc++;
                u_if.DataIn = (acc < 5) ? tbl2[acc] : 8'hEE;
            end
        end
        check_eq("t2_accepts", acc, 32'd5);
        check_eq("t3_ready_full", {31'd0, u_if.DataInReady}, 32'd0);
        low_seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (fcount != 3'd4) low_seen = 1'b1;
        end
        check_eq("t3_count_held", {31'd0, low_seen}, 32'd0);
        check_eq("t3_count_full", {29'd0, fcount}, 32'd4);
        u_if.DataInValid = 1'b0;
        for (int c = 0; c < 200 && !u_if.DataInReady; c++) begin
            tick();
        end
        check_eq("t3_ready_return", cyc - push_cyc, 32'd102);
        check_eq("t3_count_after_pop", {29'd0, fcount}, 32'd3);
        wait_idle(700);
        repeat (3) tick();
        check_eq("t2_rx_n", rx_q.size(), 32'd5);
        for (int i = 0; i < 5; i++) begin
            if (i < rx_q.size()) check_eq($sformatf("t2_rx_%0d", i), {24'd0, rx_q[i]}, {24'd0, tbl2[i]});
        end
        for (int i = 1; i < 5; i++) begin
            if (i < starts_q.size()) check_eq($sformatf("t2_gap_%0d", i), starts_q[i] - starts_q[i-1], 32'd101);
        end

        // 5: asynchronous reset mid-frame with two bytes queued.
        rx_q.delete();
        push_byte(8'h0F);
        push_byte(8'h11);
        push_byte(8'h22);
        check_eq("t5_count_pre", {29'd0, fcount}, 32'd2);
        repeat (40) tick();
        #3;
        rst_n = 1'b0;
        #1;
        check_eq("t5_sout_rst",  {31'd0, sout}, 32'd1);
        check_eq("t5_count_rst", {29'd0, fcount}, 32'd0);
        check_eq("t5_busy_rst",  {31'd0, busy}, 32'd0);
        check_eq("t5_ready_rst", {31'd0, u_if.DataInReady}, 32'd1);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;
        low_seen = 1'b0;
        for (int c = 0; c < 200; c++) begin
            tick();
            if (sout == 1'b0) low_seen = 1'b1;
        end
        check_eq("t5_no_residual", {31'd0, low_seen}, 32'd0);
        check_eq("t5_rx_n", rx_q.size(), 32'd0);
        check_eq("t5_busy_after", {31'd0, busy}, 32'd0);

        // 6: twelve bytes streamed through the 4-deep queue.
        rx_q.delete();
        acc = 0;
        u_if.DataIn      = 8'h01;
        u_if.DataInValid = 1'b1;
        for (int c = 0; c < 2000 && acc < 12; c++) begin
            rdy = u_if.DataInReady;
            tick();
            if (rdy) begin
                acc++;
                u_if.DataIn = 8'(acc + 1);
            end
        end
        u_if.DataInValid = 1'b0;
        check_eq("t6_accepts", acc, 32'd12);
        wait_idle(700);
        repeat (3) tick();
        check_eq("t6_rx_n", rx_q.size(), 32'd12);
        for (int i = 0; i < 12; i++) begin
            if (i < rx_q.size()) check_eq($sformatf("t6_rx_%0d", i), {24'd0, rx_q[i]}, i + 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
